// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial transmit scheduler.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 200000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grant is combinational from valid;
// the priority pointer moves only when the caller accepts (advance).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // prio = index of the requester that wins a tie
  logic prio;

  // pick a single winner; ties go to the requester not served last
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // after serving requester N, hand the tie-break to the other one
  always_ff @(posedge clk) begin
    if (reset)        prio <= 1'b0;
    else if (advance) prio <= grant[0];
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two byte requesters onto one serial device using a
// four-phase start/finished handshake with a per-phase abort timer.
module uart_tx_scheduler
  import serial_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          dev_start,
  output logic [DW-1:0] dev_data,
  input  logic          dev_finished,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [1:0]    timeout_err,
  input  logic          err_clear
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    grant_n, err_set, ready, arb_gnt;
  logic [DW-1:0] data_n;
  logic          expired;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   ({req1_valid, req0_valid}),
    .advance (|ready),
    .grant   (arb_gnt)
  );

  assign expired    = (cnt == CNT_MAX);
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign busy       = (state != IDLE);

  // next-state, handshake outputs and accept logic
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    data_n    = dev_data;
    err_set   = 2'b00;
    ready     = 2'b00;
    dev_start = 1'b0;
    case (state)
      IDLE: begin
        // reset gate keeps an in-flight requester from seeing a pulse
        if (!reset && (|arb_gnt)) begin
          ready   = arb_gnt;
          grant_n = arb_gnt;
          data_n  = arb_gnt[1] ? req1_data : req0_data;
          state_n = START;
        end
      end
      START: begin
        dev_start = 1'b1;
        // a completion seen on the last cycle still counts as success
        if (dev_finished) begin
          state_n = RELEASE;
        end else if (expired) begin
          err_set = grant;
          grant_n = 2'b00;
          state_n = IDLE;
        end
      end
      RELEASE: begin
        if (!dev_finished) begin
          grant_n = 2'b00;
          state_n = IDLE;
        end else if (expired) begin
          err_set = grant;
          grant_n = 2'b00;
          state_n = IDLE;
        end
      end
      default: begin
        grant_n = 2'b00;
        state_n = IDLE;
      end
    endcase
    // phase timer restarts on every state entry
    if (state_n != state)   cnt_n = '0;
    else if (state != IDLE) cnt_n = cnt + 1'b1;
    else                    cnt_n = '0;
  end

  // state, timer, owner, byte and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      grant       <= 2'b00;
      dev_data    <= '0;
      timeout_err <= 2'b00;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      grant       <= grant_n;
      dev_data    <= data_n;
      // a fresh abort beats a simultaneous clear for its own bit
      timeout_err <= (err_clear ? 2'b00 : timeout_err) | err_set;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a short abort timer.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       dev_start;
  logic [7:0] dev_data;
  logic       dev_finished = 1'b0;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] timeout_err;
  logic       err_clear = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_scheduler #(.TIMEOUT(16), .DW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .dev_start    (dev_start),
    .dev_data     (dev_data),
    .dev_finished (dev_finished),
    .grant        (grant),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  // advance one cycle; stimulus is changed and outputs sampled at negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (dev_start !== 1'b0) begin n_err++; $display("FAIL reset_dev_start got %0h exp 0", dev_start); end
    n_cmp++; if (dev_data !== 8'h00) begin n_err++; $display("FAIL reset_dev_data got %0h exp 00", dev_data); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got %0b exp 00", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0h exp 0", busy); end
    n_cmp++; if (timeout_err !== 2'b00) begin n_err++; $display("FAIL reset_err got %0b exp 00", timeout_err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic bad;
    req0_data = 8'h41; req0_valid = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL single_ready got %0b exp 01", {req1_ready, req0_ready}); end
    n_cmp++; if (dev_start !== 1'b0) begin n_err++; $display("FAIL single_start_early got %0h exp 0", dev_start); end
    step();
    req0_valid = 1'b0;
    n_cmp++; if (dev_start !== 1'b1) begin n_err++; $display("FAIL single_start got %0h exp 1", dev_start); end
    n_cmp++; if (dev_data !== 8'h41) begin n_err++; $display("FAIL single_data got %0h exp 41", dev_data); end
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL single_grant got %0b exp 01", grant); end
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL single_ready_once got %0b exp 00", {req1_ready, req0_ready}); end
    bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (dev_start !== 1'b1 || dev_data !== 8'h41 || busy !== 1'b1) bad = 1'b1;
    end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL single_hold got unstable exp start=1 data=41"); end
    dev_finished = 1'b1;
    step();
    n_cmp++; if (dev_start !== 1'b0) begin n_err++; $display("FAIL single_release_start got %0h exp 0", dev_start); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_release_busy got %0h exp 1", busy); end
    step();
    dev_finished = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %0h exp 0", busy); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL single_idle_grant got %0b exp 00", grant); end
    n_cmp++; if (dev_data !== 8'h41) begin n_err++; $display("FAIL single_data_held got %0h exp 41", dev_data); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp;
    reset = 1'b1; step(); reset = 1'b0;
    req0_data = 8'h10; req1_data = 8'h20;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp = 2'b01;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== exp) begin n_err++; $display("FAIL alt_ready[%0d] got %0b exp %0b", k, {req1_ready, req0_ready}, exp); end
      step();
      n_cmp++; if (grant !== exp) begin n_err++; $display("FAIL alt_grant[%0d] got %0b exp %0b", k, grant, exp); end
      n_cmp++; if (dev_data !== ((exp == 2'b01) ? 8'h10 : 8'h20)) begin n_err++; $display("FAIL alt_data[%0d] got %0h exp %0h", k, dev_data, (exp == 2'b01) ? 8'h10 : 8'h20); end
      dev_finished = 1'b1;
      step();
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL alt_no_ready[%0d] got %0b exp 00", k, {req1_ready, req0_ready}); end
      dev_finished = 1'b0;
      step();
      exp = {exp[0], exp[1]};
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int count;
    reset = 1'b1; step(); reset = 1'b0;
    req0_data = 8'h5A; req0_valid = 1'b1;
    #1;
    step();
    req0_valid = 1'b0;
    count = 0;
    while (dev_start === 1'b1 && count < 40) begin
      count++;
      step();
    end
    n_cmp++; if (count != 16) begin n_err++; $display("FAIL timeout_cycles got %0d exp 16", count); end
    n_cmp++; if (timeout_err !== 2'b01) begin n_err++; $display("FAIL timeout_err got %0b exp 01", timeout_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy got %0h exp 0", busy); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL timeout_grant got %0b exp 00", grant); end
  endtask

  task automatic test_err_clear();
    req1_data = 8'h33; req1_valid = 1'b1;
    #1;
    n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL clr_ready1 got %0h exp 1", req1_ready); end
    step();
    req1_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    n_cmp++; if (dev_start !== 1'b1) begin n_err++; $display("FAIL clr_last_start got %0h exp 1", dev_start); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    n_cmp++; if (timeout_err !== 2'b10) begin n_err++; $display("FAIL clr_set_wins got %0b exp 10", timeout_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy got %0h exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    req0_data = 8'h99; req0_valid = 1'b1;
    #1;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    #1;
    n_cmp++; if (dev_start !== 1'b0) begin n_err++; $display("FAIL rmid_start got %0h exp 0", dev_start); end
    n_cmp++; if (dev_data !== 8'h00) begin n_err++; $display("FAIL rmid_data got %0h exp 00", dev_data); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL rmid_grant got %0b exp 00", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %0h exp 0", busy); end
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL rmid_ready got %0b exp 00", {req1_ready, req0_ready}); end
    n_cmp++; if (timeout_err !== 2'b00) begin n_err++; $display("FAIL rmid_err got %0b exp 00", timeout_err); end
    reset = 1'b0; req0_valid = 1'b0;
    step();
    req1_data = 8'h77; req1_valid = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_err++; $display("FAIL rmid_ready1 got %0b exp 10", {req1_ready, req0_ready}); end
    step();
    req1_valid = 1'b0;
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL rmid_grant1 got %0b exp 10", grant); end
    n_cmp++; if (dev_data !== 8'h77) begin n_err++; $display("FAIL rmid_data1 got %0h exp 77", dev_data); end
    dev_finished = 1'b1;
    step();
    dev_finished = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_done got %0h exp 0", busy); end
  endtask

  task automatic test_stuck();
    req0_data = 8'hC3; req0_valid = 1'b1;
    #1;
    step();
    req0_valid = 1'b0;
    step();
    dev_finished = 1'b1;
    step();
    req1_data = 8'h3C; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if ({dev_start, req1_ready, req0_ready, busy} !== 4'b0001) begin n_err++; $display("FAIL stuck_wait[%0d] got start/rdy/busy %0b exp 0001", i, {dev_start, req1_ready, req0_ready, busy}); end
      step();
    end
    dev_finished = 1'b0;
    step();
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_err++; $display("FAIL stuck_ready1 got %0b exp 10", {req1_ready, req0_ready}); end
    step();
    req1_valid = 1'b0;
    n_cmp++; if (dev_data !== 8'h3C) begin n_err++; $display("FAIL stuck_data got %0h exp 3c", dev_data); end
    n_cmp++; if (dev_start !== 1'b1) begin n_err++; $display("FAIL stuck_start got %0h exp 1", dev_start); end
    dev_finished = 1'b1;
    step();
    dev_finished = 1'b0;
    step();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_err_clear();
    test_reset_mid();
    test_stuck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
